// File: rtl/round_pack.sv
// Two-stage IEEE-754 single-precision round-and-pack stage: stage 1 makes the rounding
// decision, stage 2 adds the increment, handles specials/overflow and packs the word.
module round_pack #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_in,
    input  logic                   nan_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W-1:0]       mantis_in,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-3:0] result,
    output logic                   flag_inexact,
    output logic                   flag_overflow,
    output logic                   flag_underflow
);

    localparam int unsigned SIG_W  = MAN_W - 2;
    localparam int unsigned FRAC_W = SIG_W - 1;
    localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;

    typedef enum logic [1:0] {RndRne, RndRtz, RndUp, RndDn} rnd_e;

    logic             w_adv;
    logic             w_inc;
    rnd_e             w_mode;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic             r_s1_nan;
    logic [EXP_W-1:0] r_s1_exp;
    logic [SIG_W-1:0] r_s1_sig;
    logic             r_s1_inc;
    logic             r_s1_inexact;
    rnd_e             r_s1_mode;

    logic [SIG_W:0]    w_sum;
    logic              w_exp_zero;
    logic [EXP_W-1:0]  w_exp_f;
    logic [FRAC_W-1:0] w_frac;
    logic              w_ovf_inf;
    logic [RES_W-1:0]  w_result;
    logic              w_inexact;
    logic              w_overflow;
    logic              w_underflow;

    logic             r_out_valid;
    logic [RES_W-1:0] r_result;
    logic             r_inexact;
    logic             r_overflow;
    logic             r_underflow;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_mode   = rnd_e'(rnd_mode);

    always_comb begin
        w_inc = 1'b0;
        unique case (w_mode)
            RndRne: w_inc = mantis_in[1] & (mantis_in[0] | mantis_in[2]);
            RndRtz: w_inc = 1'b0;
            RndUp:  w_inc = !sign_in & (mantis_in[1] | mantis_in[0]);
            RndDn:  w_inc = sign_in & (mantis_in[1] | mantis_in[0]);
            default: w_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_sig     <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_mode    <= RndRne;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_sign    <= sign_in;
            r_s1_nan     <= nan_in;
            r_s1_exp     <= exp_in;
            r_s1_sig     <= mantis_in[MAN_W-1:2];
            r_s1_inc     <= w_inc;
            r_s1_inexact <= mantis_in[1] | mantis_in[0];
            r_s1_mode    <= w_mode;
        end
    end

    assign w_sum      = {1'b0, r_s1_sig} + {{SIG_W{1'b0}}, r_s1_inc};
    assign w_exp_zero = (r_s1_exp == '0);
    // A subnormal that rounds into the hidden bit becomes the smallest normal.
    assign w_exp_f    = w_exp_zero ? {{(EXP_W-1){1'b0}}, w_sum[SIG_W-1]}
                                   : r_s1_exp + {{(EXP_W-1){1'b0}}, w_sum[SIG_W]};
    assign w_frac     = (!w_exp_zero && w_sum[SIG_W]) ? '0 : w_sum[FRAC_W-1:0];
    assign w_ovf_inf  = (r_s1_mode == RndRne) || (r_s1_mode == RndUp && !r_s1_sign) ||
                        (r_s1_mode == RndDn && r_s1_sign);

    always_comb begin
        w_result    = {r_s1_sign, w_exp_f, w_frac};
        w_inexact   = r_s1_inexact;
        w_overflow  = 1'b0;
        w_underflow = w_exp_zero & r_s1_inexact;
        if (r_s1_nan) begin
            w_result    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
            w_inexact   = 1'b0;
            w_underflow = 1'b0;
        end else if (r_s1_exp == {EXP_W{1'b1}}) begin
            w_result    = {r_s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_inexact   = 1'b0;
            w_underflow = 1'b0;
        end else if (w_exp_zero && r_s1_sig == '0) begin
            w_result    = {r_s1_sign, {(RES_W-1){1'b0}}};
            w_inexact   = 1'b0;
            w_underflow = 1'b0;
        end else if (w_exp_f == {EXP_W{1'b1}}) begin
            w_overflow  = 1'b1;
            w_inexact   = 1'b1;
            w_underflow = 1'b0;
            w_result    = w_ovf_inf ? {r_s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                                    : {r_s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_inexact   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            r_result    <= w_result;
            r_inexact   <= w_inexact;
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
        end
    end

    assign out_valid      = r_out_valid;
    assign result         = r_result;
    assign flag_inexact   = r_inexact;
    assign flag_overflow  = r_overflow;
    assign flag_underflow = r_underflow;

endmodule

// File: tb/tb_round_pack.sv
// Directed bench for round_pack: hand-computed rounding vectors, a stall/backpressure stream
// and a mid-stream reset, checked with immediate assertions.
module tb_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic        nan_in;
    logic [7:0]  exp_in;
    logic [25:0] mantis_in;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_inexact;
    logic        flag_overflow;
    logic        flag_underflow;

    int n_vec = 0;
    int n_err = 0;

    logic        mon_en = 1'b0;
    logic [31:0] got_q[$];

    round_pack #(.EXP_W(8), .MAN_W(26)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sign_in        (sign_in),
        .nan_in         (nan_in),
        .exp_in         (exp_in),
        .mantis_in      (mantis_in),
        .rnd_mode       (rnd_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_inexact   (flag_inexact),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && out_valid && out_ready) got_q.push_back(result);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {overflow, underflow, inexact}.
    task automatic run_vec(input string tag, input logic s, input logic n, input logic [7:0] e,
                           input logic [25:0] m, input logic [1:0] md,
                           input logic [31:0] want, input logic [2:0] want_fl);
        int waited;
        sign_in   = s;
        nan_in    = n;
        exp_in    = e;
        mantis_in = m;
        rnd_mode  = md;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        waited   = 0;
        tick();
        while (!out_valid && waited < 5) begin
            tick();
            waited++;
        end
        check({tag, "_lat"}, 32'(waited), 32'd0);
        check({tag, "_res"}, result, want);
        check({tag, "_flg"}, {29'd0, flag_overflow, flag_underflow, flag_inexact},
              {29'd0, want_fl});
        tick();
    endtask

    initial begin
        logic [31:0] exp_stream[5];
        int          guard;

        exp_stream = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sign_in   = 1'b0;
        nan_in    = 1'b0;
        exp_in    = '0;
        mantis_in = '0;
        rnd_mode  = 2'd0;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, flag_overflow, flag_underflow, flag_inexact}, 32'd0);
        rst = 1'b0;
        tick();

        run_vec("one",        1'b0, 1'b0, 8'd127, 26'h2000000, 2'd0, 32'h3F800000, 3'b000);
        run_vec("tie_even",   1'b0, 1'b0, 8'd127, 26'h2000002, 2'd0, 32'h3F800000, 3'b001);
        run_vec("tie_odd",    1'b0, 1'b0, 8'd127, 26'h2000006, 2'd0, 32'h3F800002, 3'b001);
        run_vec("carry_exp",  1'b0, 1'b0, 8'd127, 26'h3FFFFFE, 2'd0, 32'h40000000, 3'b001);
        run_vec("ovf_rne",    1'b0, 1'b0, 8'd254, 26'h3FFFFFE, 2'd0, 32'h7F800000, 3'b101);
        run_vec("max_rtz",    1'b0, 1'b0, 8'd254, 26'h3FFFFFE, 2'd1, 32'h7F7FFFFF, 3'b001);
        run_vec("ovf_up_pos", 1'b0, 1'b0, 8'd254, 26'h3FFFFFF, 2'd2, 32'h7F800000, 3'b101);
        run_vec("up_neg",     1'b1, 1'b0, 8'd254, 26'h3FFFFFF, 2'd2, 32'hFF7FFFFF, 3'b001);
        run_vec("dn_pos",     1'b0, 1'b0, 8'd254, 26'h3FFFFFF, 2'd3, 32'h7F7FFFFF, 3'b001);
        run_vec("ovf_dn_neg", 1'b1, 1'b0, 8'd254, 26'h3FFFFFF, 2'd3, 32'hFF800000, 3'b101);
        run_vec("nan",        1'b1, 1'b1, 8'd254, 26'h3FFFFFF, 2'd0, 32'h7FC00000, 3'b000);
        run_vec("inf_pass",   1'b1, 1'b0, 8'd255, 26'h2000003, 2'd0, 32'hFF800000, 3'b000);
        run_vec("sub_promote",1'b0, 1'b0, 8'd0,   26'h1FFFFFE, 2'd0, 32'h00800000, 3'b011);
        run_vec("sub_exact",  1'b0, 1'b0, 8'd0,   26'h0000004, 2'd0, 32'h00000001, 3'b000);
        run_vec("zero_neg",   1'b1, 1'b0, 8'd0,   26'h0000000, 2'd0, 32'h80000000, 3'b000);

        // Four back-to-back beats, then a 3-cycle stall with a fifth beat waiting.
        mon_en   = 1'b1;
        sign_in  = 1'b0;
        nan_in   = 1'b0;
        rnd_mode = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_in    = 8'(127 + k);
            mantis_in = 26'h2000000;
            tick();
        end
        exp_in    = 8'd131;
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_hold", result, 32'h40800000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        guard    = 0;
        while (got_q.size() < 5 && guard < 10) begin
            tick();
            guard++;
        end
        tick();
        mon_en = 1'b0;
        check("stream_count", 32'(got_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) check("stream_word", got_q[k], exp_stream[k]);
        end

        // Reset with beats in flight.
        in_valid  = 1'b1;
        exp_in    = 8'd127;
        mantis_in = 26'h2000000;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_drained", {31'd0, out_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
